// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT wait states, big-endian
// byte/half/word access on an internal RAM with zero/sign-extended loads.
module dmem_responder #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  dsize,
  input  logic        loadext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        misalign,
  output logic        stall
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              r_state, w_state_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic                r_we;
  logic [1:0]          r_dsize;
  logic                r_ext;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_ack;
  logic                r_mis;
  logic [31:0]         r_mem [DEPTH];

  logic                w_access;
  logic                w_latch;
  logic                w_we;
  logic [1:0]          w_dsize;
  logic                w_ext;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wdata;
  logic [ADDR_W-3:0]   w_idx;
  logic [1:0]          w_off;
  logic [31:0]         w_word;
  logic [4:0]          w_bsh;
  logic [4:0]          w_hsh;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic                w_mis;
  logic [31:0]         w_load;
  logic [31:0]         w_mask;
  logic [31:0]         w_sdata;
  logic [31:0]         w_merged;
  logic                w_unused;

  assign w_unused = ^addr[31:ADDR_W];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_access     = 1'b0;
    w_latch      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req) begin
          w_latch = 1'b1;
          if (WAIT == 0) begin
            w_access     = 1'b1;
            w_state_next = StResp;
          end else begin
            w_cnt_next   = 4'(WAIT);
            w_state_next = StWait;
          end
        end
      end
      StWait: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_access     = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // A zero-wait access happens on the accepting edge, so use the live request
  always_comb begin
    if (r_state == StIdle) begin
      w_we    = we;
      w_dsize = dsize;
      w_ext   = loadext;
      w_addr  = addr[ADDR_W-1:0];
      w_wdata = wdata;
    end else begin
      w_we    = r_we;
      w_dsize = r_dsize;
      w_ext   = r_ext;
      w_addr  = r_addr;
      w_wdata = r_wdata;
    end
  end

  assign w_idx  = w_addr[ADDR_W-1:2];
  assign w_off  = w_addr[1:0];
  assign w_word = r_mem[w_idx];
  assign w_bsh  = {~w_off, 3'b000};
  assign w_hsh  = w_off[1] ? 5'd0 : 5'd16;
  assign w_byte = 8'(w_word >> w_bsh);
  assign w_half = 16'(w_word >> w_hsh);

  always_comb begin
    w_mis   = 1'b0;
    w_load  = w_word;
    w_mask  = 32'hFFFF_FFFF;
    w_sdata = w_wdata;
    case (w_dsize)
      2'b00: begin
        w_load  = {{24{w_ext & w_byte[7]}}, w_byte};
        w_mask  = 32'h0000_00FF << w_bsh;
        w_sdata = {24'd0, w_wdata[7:0]} << w_bsh;
      end
      2'b01: begin
        w_mis   = w_off[0];
        w_load  = {{16{w_ext & w_half[15]}}, w_half};
        w_mask  = 32'h0000_FFFF << w_hsh;
        w_sdata = {16'd0, w_wdata[15:0]} << w_hsh;
      end
      default: w_mis = (w_off != 2'b00);
    endcase
    if (w_mis) w_load = '0;
  end

  assign w_merged = (w_word & ~w_mask) | (w_sdata & w_mask);

  // RAM is deliberately not reset
  always_ff @(posedge clock) begin
    if (w_access && w_we && !w_mis) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_dsize <= '0;
      r_ext   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= w_access;
      r_mis   <= w_access & w_mis;
      if (w_latch) begin
        r_we    <= we;
        r_dsize <= dsize;
        r_ext   <= loadext;
        r_addr  <= addr[ADDR_W-1:0];
        r_wdata <= wdata;
      end
      if (w_access && !w_we) r_rdata <= w_load;
    end
  end

  assign rdata    = r_rdata;
  assign ack      = r_ack;
  assign misalign = r_mis;
  assign stall    = ((r_state == StIdle) && req) || (r_state == StWait);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: issuer pushes expected responses from a byte-array memory
// model; a monitor checks stall/ack timing and pops on every expected ack.
module tb_dmem_responder;
  localparam int WAIT_M = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, we, loadext;
  logic [1:0]  dsize;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ack, misalign, stall;

  logic        s_req, s_we;
  logic [31:0] s_wdata;
  logic [31:0] rdata0, rdata15;
  logic        ack0, ack15, mis0, mis15, stall0, stall15;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(12), .WAIT(WAIT_M)) u_dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .dsize(dsize), .loadext(loadext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .misalign(misalign), .stall(stall)
  );

  dmem_responder #(.ADDR_W(12), .WAIT(0)) u_w0 (
    .clock(clock), .reset(reset), .req(s_req), .we(s_we), .dsize(2'b10), .loadext(1'b0),
    .addr(32'h0000_0008), .wdata(s_wdata), .rdata(rdata0), .ack(ack0), .misalign(mis0),
    .stall(stall0)
  );

  dmem_responder #(.ADDR_W(12), .WAIT(15)) u_w15 (
    .clock(clock), .reset(reset), .req(s_req), .we(s_we), .dsize(2'b10), .loadext(1'b0),
    .addr(32'h0000_0008), .wdata(s_wdata), .rdata(rdata15), .ack(ack15), .misalign(mis15),
    .stall(stall15)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mb[64];
  logic [31:0] last_rd;
  int          total = 0;
  int          bad = 0;
  int          ack_cnt = 0;
  int          cyc = 0;
  int          start = 0;
  bit          busy = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memory is 64 bytes, byte address a holds the big-endian byte a
  task automatic model(input logic w, input logic [1:0] sz, input logic e,
                       input logic [31:0] a, input logic [31:0] d, output exp_t x);
    int b;
    bit mis;
    logic [31:0] v;
    b   = int'(a[5:0]);
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    x.mis = mis;
    if (w) begin
      if (!mis) begin
        case (sz)
          2'b00: mb[b] = d[7:0];
          2'b01: begin mb[b] = d[15:8]; mb[b+1] = d[7:0]; end
          default: for (int i = 0; i < 4; i++) mb[b+i] = d[31-8*i -: 8];
        endcase
      end
      x.rdata = last_rd;
    end else begin
      if (mis) v = '0;
      else begin
        case (sz)
          2'b00:   v = {{24{e & mb[b][7]}}, mb[b]};
          2'b01:   v = {{16{e & mb[b][7]}}, mb[b], mb[b+1]};
          default: v = {mb[b], mb[b+1], mb[b+2], mb[b+3]};
        endcase
      end
      last_rd = v;
      x.rdata = v;
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic e,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    int   old;
    model(w, sz, e, a, d, x);
    sb.push_back(x);
    old = ack_cnt;
    we = w; dsize = sz; loadext = e; addr = a; wdata = d; req = 1'b1;
    @(negedge clock);
    // Scramble the request lines; the latched request must still complete
    req = 1'b0; we = ~w; addr = $urandom(); wdata = $urandom(); dsize = 2'($urandom());
    for (int i = 0; i < 40 && ack_cnt == old; i++) @(negedge clock);
    if (ack_cnt == old) begin
      total++; bad++;
      $display("FAIL ack_timeout: got no ack expected ack for addr %h", a);
      sb.delete();
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      #2;
      cyc++;
      if (mon_en) begin
        if (!busy && req) begin busy = 1; start = cyc; end
        if (busy) begin
          chk("stall_busy", {31'd0, stall}, {31'd0, cyc <= start + WAIT_M});
          if (cyc == start + WAIT_M + 1) begin
            chk("ack", {31'd0, ack}, 32'd1);
            if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
            else begin
              x = sb.pop_front();
              chk("rdata", rdata, x.rdata);
              chk("misalign", {31'd0, misalign}, {31'd0, x.mis});
            end
            busy = 0;
            ack_cnt++;
          end else chk("ack_early", {31'd0, ack}, 32'd0);
        end else begin
          chk("stall_idle", {31'd0, stall}, {31'd0, req});
          chk("ack_idle", {31'd0, ack}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    reset = 1'b0; req = 1'b0; we = 1'b0; dsize = 2'b10; loadext = 1'b0;
    addr = '0; wdata = '0; s_req = 1'b0; s_we = 1'b0; s_wdata = 32'hA5A5_0F0F;
    last_rd = '0;
    #12;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    mon_en = 1;
    @(negedge clock);

    for (int i = 0; i < 16; i++) issue(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom());
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF55);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'hABCD_1234);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h1004, 32'hCAFE_F00D);
    issue(1'b0, 2'b10, 1'b0, 32'h0004, 32'h0);

    for (int n = 0; n < 150; n++) begin
      a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      issue(1'b1 & 1'($urandom()), 2'($urandom()), 1'($urandom()), a, $urandom());
    end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // Reset in the middle of a store's wait states drops the store
    mon_en = 0;
    we = 1'b1; dsize = 2'b10; addr = 32'h20; wdata = 32'hFFFF_FFFF; req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_mis", {31'd0, misalign}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    busy = 0;
    last_rd = '0;
    mon_en = 1;
    @(negedge clock);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // Zero and maximum wait-state instances: store, then loads with req held
    s_we = 1'b1; s_req = 1'b1;
    @(negedge clock);
    s_req = 1'b0;
    repeat (20) @(negedge clock);
    s_we = 1'b0; s_req = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #2;
      if (k < 8) begin
        chk("w0_ack", {31'd0, ack0}, {31'd0, k % 2 == 1});
        chk("w0_stall", {31'd0, stall0}, {31'd0, k % 2 == 0});
        if (ack0) chk("w0_rdata", rdata0, 32'hA5A5_0F0F);
        chk("w0_mis", {31'd0, mis0}, 32'd0);
      end
      chk("w15_ack", {31'd0, ack15}, {31'd0, k == 16});
      chk("w15_stall", {31'd0, stall15}, {31'd0, k <= 15});
      if (k == 16) begin
        chk("w15_rdata", rdata15, 32'hA5A5_0F0F);
        chk("w15_mis", {31'd0, mis15}, 32'd0);
      end
      @(negedge clock);
    end
    s_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
